// File: rtl/spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_responder
// Purpose  : SPI mode-0 slave. The SCLK, CS and MOSI pins are oversampled in
//            the local clk domain. Each received word is delivered with a
//            one-cycle valid pulse. Each reply word is taken through a
//            valid/ready load strobe.
// Ports    : clk, rst (sync, active-low)
//            sclk_i, cs_i, mosi_i  - SPI pins from the master
//            miso_o                - SPI data back to the master (registered)
//            tx_data_i/tx_valid_i/tx_ready_o - reply word handshake
//            rx_data_o/rx_valid_o  - last received word and update pulse
//            frame_active_o        - high while a frame is active
//            abort_err_o           - pulse when CS rises mid-word
// Options  : SPI_SLAVE_ECHO_EN - when no reply word is offered, the last
//            received word is sent back instead of IDLE_BYTE.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_responder #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = 8'hFF,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk_i,
    input  logic                  cs_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  frame_active_o,
    output logic                  abort_err_o
);

    localparam int CNT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    localparam logic [CNT_W-1:0]   c_last_bit   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]   c_cnt_one    = CNT_W'(1);
    localparam logic [FLUSH_W-1:0] c_flush_done = FLUSH_W'(SYNC_STAGES);
    localparam logic [FLUSH_W-1:0] c_flush_one  = FLUSH_W'(1);

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACTIVE    = 2'd2
    } state_t;

    // Synchronizer chains; index 0 is the pin side.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    state_t                 state_q,    state_d;
    logic [FLUSH_W-1:0]     flush_q,    flush_d;
    logic [CNT_W-1:0]       bit_cnt_q,  bit_cnt_d;
    logic                   boundary_q, boundary_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_data_q,  rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   abort_q,    abort_d;
    logic                   miso_q,     miso_d;

    logic                   w_sclk;
    logic                   w_cs;
    logic                   w_mosi;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic                   w_load;
    logic [DATA_WIDTH-1:0]  w_fill_word;
    logic [DATA_WIDTH-1:0]  w_load_word;

    assign w_sclk      = sclk_sync_q[SYNC_STAGES-1];
    assign w_cs        = cs_sync_q[SYNC_STAGES-1];
    assign w_mosi      = mosi_sync_q[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk & ~sclk_prev_q;
    assign w_sclk_fall = ~w_sclk &  sclk_prev_q;
    assign w_cs_rise   =  w_cs   & ~cs_prev_q;
    assign w_cs_fall   = ~w_cs   &  cs_prev_q;

`ifdef SPI_SLAVE_ECHO_EN
    // Loopback: with no reply offered, return the last completed word.
    assign w_fill_word = rx_data_q;
`else
    assign w_fill_word = IDLE_BYTE;
`endif

    assign w_load_word = tx_valid_i ? tx_data_i : w_fill_word;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        bit_cnt_d  = bit_cnt_q;
        boundary_d = boundary_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        abort_d    = 1'b0;
        w_load     = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                // The CS chain is preset to 1 by reset, so it only reflects
                // the pin after SYNC_STAGES cycles. Waiting for that flush
                // keeps a reset taken mid-frame from treating the still-low
                // CS as a fresh falling edge.
                if (flush_q != c_flush_done) begin
                    flush_d = flush_q + c_flush_one;
                end else if (w_cs) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (w_cs_fall) begin
                    state_d    = ST_ACTIVE;
                    bit_cnt_d  = '0;
                    boundary_d = 1'b0;
                    w_load     = 1'b1;
                end
            end

            ST_ACTIVE: begin
                // CS rise has priority over any SCLK edge in the same cycle.
                if (w_cs_rise) begin
                    state_d    = ST_IDLE;
                    boundary_d = 1'b0;
                    bit_cnt_d  = '0;
                    abort_d    = (bit_cnt_q != '0);
                end else if (w_sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], w_mosi};
                    if (bit_cnt_q == c_last_bit) begin
                        rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], w_mosi};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        boundary_d = 1'b1;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + c_cnt_one;
                    end
                end else if (w_sclk_fall) begin
                    // The falling edge that follows a word's last sample
                    // brings in the next reply word instead of shifting.
                    if (boundary_q) begin
                        w_load     = 1'b1;
                        boundary_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end

            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase

        if (w_load) begin
            tx_shift_d = w_load_word;
        end

        // MISO is registered from the next shift value so it changes in the
        // same cycle as the shift register.
        miso_d = (state_d == ST_ACTIVE) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= ST_WAIT_IDLE;
            flush_q     <= '0;
            bit_cnt_q   <= '0;
            boundary_q  <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            abort_q     <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   cs_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= w_sclk;
            cs_prev_q   <= w_cs;
            state_q     <= state_d;
            flush_q     <= flush_d;
            bit_cnt_q   <= bit_cnt_d;
            boundary_q  <= boundary_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            abort_q     <= abort_d;
            miso_q      <= miso_d;
        end
    end

    // The load strobe is held low while reset is asserted.
    assign tx_ready_o     = w_load & rst;
    assign miso_o         = miso_q;
    assign rx_data_o      = rx_data_q;
    assign rx_valid_o     = rx_valid_q;
    assign abort_err_o    = abort_q;
    assign frame_active_o = (state_q == ST_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_responder
// Purpose  : Self-checking bench for spi_slave_responder. A behavioural SPI
//            master drives the pins; expected received words are queued and
//            a monitor compares them when rx_valid pulses. A feeder process
//            presents reply words through the tx handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_responder;

    localparam int H = 6;   // clk cycles per SCLK level

`ifdef SPI_SLAVE_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk_i;
    logic       cs_i;
    logic       mosi_i;
    logic       miso_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       frame_active_o;
    logic       abort_err_o;

    int n_checks  = 0;
    int n_pass    = 0;
    int rx_cnt    = 0;
    int ready_cnt = 0;
    int hs_cnt    = 0;
    int abort_cnt = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    spi_slave_responder #(
        .DATA_WIDTH (8),
        .IDLE_BYTE  (8'hFF),
        .SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sclk_i        (sclk_i),
        .cs_i          (cs_i),
        .mosi_i        (mosi_i),
        .miso_o        (miso_o),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .frame_active_o(frame_active_o),
        .abort_err_o   (abort_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: scoreboard for received words plus pulse counters.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rx_valid_o) begin
                    rx_cnt++;
                    if (exp_rx.size() == 0)
                        check("rx_valid_unexpected", {31'd0, rx_valid_o}, 32'd0);
                    else
                        check("rx_data", {24'd0, rx_data_o}, {24'd0, exp_rx.pop_front()});
                end
                if (tx_ready_o)               ready_cnt++;
                if (tx_ready_o && tx_valid_i) hs_cnt++;
                if (abort_err_o)              abort_cnt++;
            end
        end
    end

    // Feeder: presents queued reply words, drops valid after each transfer.
    initial begin
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_valid_i && tx_ready_o && rst) begin
                @(posedge clk);
                #1;
                tx_valid_i = 1'b0;
            end else if (!tx_valid_i && tx_q.size() > 0) begin
                tx_data_i  = tx_q.pop_front();
                tx_valid_i = 1'b1;
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    // Mode-0 master: MOSI set while SCLK low, MISO captured just before rise.
    task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] cap);
        cap = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi_i = d[7-i];
            repeat (H) @(negedge clk);
            cap    = {cap[6:0], miso_o};
            sclk_i = 1'b1;
            repeat (H) @(negedge clk);
            sclk_i = 1'b0;
        end
    endtask

    task automatic cs_start();
        int r0;
        r0   = ready_cnt;
        cs_i = 1'b0;
        repeat (H) @(negedge clk);
        check("tx_ready_at_cs_fall", ready_cnt - r0, 1);
        check("frame_active_in_frame", {31'd0, frame_active_o}, 32'd1);
    endtask

    task automatic cs_end();
        repeat (H) @(negedge clk);
        cs_i = 1'b1;
        repeat (2*H) @(negedge clk);
        check("frame_active_after_end", {31'd0, frame_active_o}, 32'd0);
        check("miso_idle", {31'd0, miso_o}, 32'd0);
    endtask

    initial begin
        logic [7:0] cap;
        int         h0, r0, a0, x0;

        rst    = 1'b0;
        sclk_i = 1'b0;
        cs_i   = 1'b1;
        mosi_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_miso",         {31'd0, miso_o},         32'd0);
        check("reset_tx_ready",     {31'd0, tx_ready_o},     32'd0);
        check("reset_rx_valid",     {31'd0, rx_valid_o},     32'd0);
        check("reset_rx_data",      {24'd0, rx_data_o},      32'd0);
        check("reset_frame_active", {31'd0, frame_active_o}, 32'd0);
        check("reset_abort_err",    {31'd0, abort_err_o},    32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 1: no reply offered, receive A5, MISO idle word
        exp_rx.push_back(8'hA5);
        x0 = rx_cnt;
        cs_start();
        spi_bits(8'hA5, 8, cap);
        check("t1_miso", {24'd0, cap}, ECHO ? 32'h00 : 32'hFF);
        cs_end();
        check("t1_rx_count", rx_cnt - x0, 1);

        // 2: reply 3C offered before CS fall
        tx_q.push_back(8'h3C);
        repeat (4) @(negedge clk);
        h0 = hs_cnt;
        exp_rx.push_back(8'h00);
        cs_start();
        check("t2_handshake_at_cs_fall", hs_cnt - h0, 1);
        spi_bits(8'h00, 8, cap);
        check("t2_miso", {24'd0, cap}, 32'h3C);
        cs_end();

        // 3: two back-to-back words in one frame
        tx_q.push_back(8'hC3);
        tx_q.push_back(8'h81);
        repeat (4) @(negedge clk);
        h0 = hs_cnt;
        x0 = rx_cnt;
        exp_rx.push_back(8'h12);
        exp_rx.push_back(8'h34);
        cs_start();
        spi_bits(8'h12, 8, cap);
        check("t3_miso_word0", {24'd0, cap}, 32'hC3);
        spi_bits(8'h34, 8, cap);
        check("t3_miso_word1", {24'd0, cap}, 32'h81);
        cs_end();
        check("t3_handshakes", hs_cnt - h0, 2);
        check("t3_rx_count", rx_cnt - x0, 2);

        // 4: CS rises after 5 bits -> abort, then a clean frame
        a0 = abort_cnt;
        x0 = rx_cnt;
        cs_start();
        spi_bits(8'hE7, 5, cap);
        cs_end();
        check("t4_abort_pulse", abort_cnt - a0, 1);
        check("t4_no_rx_valid", rx_cnt - x0, 0);
        exp_rx.push_back(8'h5A);
        cs_start();
        spi_bits(8'h5A, 8, cap);
        cs_end();
        check("t4_no_extra_abort", abort_cnt - a0, 1);

        // 5: reset after 3 bits with CS held low
        x0 = rx_cnt;
        cs_start();
        spi_bits(8'hAA, 3, cap);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        r0 = ready_cnt;
        spi_bits(8'h55, 5, cap);
        check("t5_frame_inactive", {31'd0, frame_active_o}, 32'd0);
        check("t5_no_ready", ready_cnt - r0, 0);
        check("t5_rx_data_cleared", {24'd0, rx_data_o}, 32'd0);
        check("t5_miso_quiet", {24'd0, cap}, 32'd0);
        repeat (H) @(negedge clk);
        cs_i = 1'b1;
        repeat (2*H) @(negedge clk);
        check("t5_no_rx_valid", rx_cnt - x0, 0);
        exp_rx.push_back(8'hF0);
        cs_start();
        spi_bits(8'hF0, 8, cap);
        cs_end();
        check("t5_rx_after_reset", {24'd0, rx_data_o}, 32'hF0);

        // 6: fill word when no reply is offered (loopback when enabled)
        exp_rx.push_back(8'h6E);
        cs_start();
        spi_bits(8'h6E, 8, cap);
        check("t6_miso_frame1", {24'd0, cap}, ECHO ? 32'hF0 : 32'hFF);
        cs_end();
        exp_rx.push_back(8'h00);
        cs_start();
        spi_bits(8'h00, 8, cap);
        check("t6_miso_frame2", {24'd0, cap}, ECHO ? 32'h6E : 32'hFF);
        cs_end();

        repeat (5) @(negedge clk);
        check("rx_queue_drained", exp_rx.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI mode-0 slave, the far end of the team's SPI master.
- Receives SCLK/CS/MOSI from the master and drives MISO back.
- Oversamples the master's signals in the local clk domain. Delivers each received byte on a valid pulse.
- Takes each reply byte through a valid/ready handshake. Sits between the SPI pins and register/command logic.

Parameters:
- DATA_WIDTH, 8, bits per SPI word; MSB first.
- IDLE_BYTE, 8'hFF, word shifted out when no reply byte is offered at a word boundary.
- SYNC_STAGES, 2, flop stages on SCLK/CS/MOSI (min 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- SCLK  in  1  SPI clock from master; idle low.
- CS  in  1  chip select, active-low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- tx_data  in  DATA_WIDTH  next reply word.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  load strobe; transfer occurs when tx_valid & tx_ready.
- rx_data  out  DATA_WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- frame_active  out  1  high while in ACTIVE.
- abort_err  out  1  one-cycle pulse: CS rose mid-word.

Behaviour:
- Reset (rst==0 at posedge clk) values:
  - All outputs 0.
  - tx/rx shift registers 0, bit_cnt 0, state WAIT_IDLE.
  - CS synchronizer chain loads 1; SCLK and MOSI chains load 0.
- Synchronization and edge detection:
  - SCLK, CS and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected from the last two synced SCLK/CS samples.
  - Pin-to-detect latency is SYNC_STAGES+1 clk.
- Timing requirement: each SCLK level and the CS-low-to-first-rise gap hold for ≥1 clk when SCLK comes from the same clk, ≥3 clk otherwise.
- WAIT_IDLE:
  - Ignores all edges.
  - Moves to IDLE once synced CS==1.
  - Guarantees that a reset mid-frame discards the rest of that frame.
- IDLE:
  - MISO=0.
  - On CS falling edge: go ACTIVE, bit_cnt=0, perform a word load.
- Word load (single cycle):
  - tx_ready=1 that cycle only.
  - If tx_valid=1, the tx shift register takes tx_data; otherwise it takes IDLE_BYTE.
  - tx_ready is never high outside a load cycle.
- ACTIVE, MISO: MISO = tx shift register MSB, registered output.
- ACTIVE, SCLK rising edge (sample):
  - rx_shift <= {rx_shift[DATA_WIDTH-2:0], MOSI_synced}.
  - bit_cnt increments.
  - If bit_cnt was DATA_WIDTH-1: rx_data <= completed word, rx_valid=1 next cycle, bit_cnt wraps to 0, boundary flag set.
- ACTIVE, SCLK falling edge (shift):
  - If boundary flag set: word load, clear flag.
  - Else: tx shift left by 1, fill 0.
- Back-to-back words in one frame run with no gap.
- No backpressure on rx: a new word overwrites rx_data.
- CS rising edge in ACTIVE:
  - Always go IDLE.
  - If bit_cnt!=0: abort_err pulses, partial word discarded, no rx_valid.
  - If bit_cnt==0: clean end, no error.
  - A pending boundary flag is cleared and no load occurs.
- Simultaneous events:
  - CS rising edge detected in the same cycle as an SCLK edge: CS wins, the SCLK edge is ignored.
  - rx_valid from a completed word and a same-cycle CS rise are both honoured.
- frame_active=1 exactly when state==ACTIVE.

Optional Feature:
- Macro: SPI_SLAVE_ECHO_EN.
- Defined: at a word load with tx_valid=0, the tx shift register takes the last completed rx_data instead of IDLE_BYTE (loopback). After reset, with no word yet received, it takes 0.
- Undefined: IDLE_BYTE is used; no extra logic.

Test Plan:
- Reset, CS high, tx_valid=0, master sends 8'hA5 → rx_valid pulse once, rx_data=8'hA5, MISO bits = 8'hFF, tx_ready one pulse at CS fall.
- tx_data=8'h3C with tx_valid=1 before CS fall, master sends 8'h00 → MISO shifts 0,0,1,1,1,1,0,0 on falling edges; handshake completes at CS-fall load.
- One frame of two words: MOSI 8'h12 then 8'h34, tx_data 8'hC3 then 8'h81 → two rx_valid pulses (12, 34); second tx_ready at the 8th falling edge; MISO = C3 then 81.
- CS rises after 5 SCLK rises → abort_err one pulse, no rx_valid, frame_active drops; next full frame 8'h5A is received correctly.
- rst asserted after 3 bits with CS held low, then released → no rx_valid for that frame, no response until CS goes high; next frame 8'hF0 is received normally.
- With SPI_SLAVE_ECHO_EN: frame 1 MOSI 8'h6E, frame 2 tx_valid=0 → frame 2 MISO = 8'h6E. Without the macro → 8'hFF.
